// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared types and defaults for the in-order issue scoreboard
package issue_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_MAX_INFLIGHT = 8;
  typedef enum logic [1:0] {RUN, DRAIN, IDLE} sb_state_e;
endpackage

// File: rtl/sb_hazard_chk.sv
// sb_hazard_chk: RAW/WAW detection against the pending vector, with same-cycle writeback bypass
module sb_hazard_chk import issue_scoreboard_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic [NUM_REGS-1:0]   pend,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_wren,
  input  logic                  wb_vld,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  raw,
  output logic                  waw
);
  logic [NUM_REGS-1:0] live;
  assign live = pend & ~(NUM_REGS'(wb_vld) << wb_rd);
  assign raw = (rs1_used && live[rs1_addr]) || (rs2_used && live[rs2_addr]);
  assign waw = rd_wren && rd_addr != '0 && live[rd_addr];
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks pending destinations and in-flight count, gates issue, handles drain
module issue_scoreboard import issue_scoreboard_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  localparam int IW = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_issue_vld,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rd_wren,
  input  logic                  i_wb_vld,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_drain,
  output logic                  o_issue_rdy,
  output logic                  o_stall,
  output logic [IW-1:0]         o_inflight,
  output logic                  o_drained,
  output logic [31:0]           o_stall_cnt,
  output logic                  o_wb_err
);
  sb_state_e state, state_nxt;
  logic [NUM_REGS-1:0] pend, pend_set, pend_clr;
  logic [IW-1:0] inflight_nxt;
  logic raw, waw, cap, issue, wb_bad;
  sb_hazard_chk #(.NUM_REGS(NUM_REGS)) u_hz (
    .pend(pend), .rs1_addr(i_rs1_addr), .rs2_addr(i_rs2_addr),
    .rs1_used(i_rs1_used), .rs2_used(i_rs2_used),
    .rd_addr(i_rd_addr), .rd_wren(i_rd_wren),
    .wb_vld(i_wb_vld), .wb_rd(i_wb_rd), .raw(raw), .waw(waw)
  );
  assign cap = o_inflight == IW'(MAX_INFLIGHT) && !i_wb_vld;
  assign o_issue_rdy = state == RUN && !raw && !waw && !cap;
  assign o_stall = i_issue_vld && !o_issue_rdy;
  assign o_drained = state == IDLE;
  assign issue = i_issue_vld && o_issue_rdy;
  // x0 is never tracked, so bit 0 is masked out of every set
  assign pend_set = (issue && i_rd_wren) ? (NUM_REGS'(1) << i_rd_addr) & ~NUM_REGS'(1) : '0;
  assign pend_clr = i_wb_vld ? NUM_REGS'(1) << i_wb_rd : '0;
  assign wb_bad = i_wb_vld && (o_inflight == '0 || (i_wb_rd != '0 && !pend[i_wb_rd]));
  assign inflight_nxt = o_inflight + IW'(issue) - IW'(i_wb_vld && o_inflight != '0);
  always_comb begin
    state_nxt = state == RUN   ? (i_drain ? DRAIN : RUN) :
                state == DRAIN ? (!i_drain ? RUN : inflight_nxt == '0 ? IDLE : DRAIN) :
                                 (i_drain ? IDLE : RUN);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RUN;
      pend        <= '0;
      o_inflight  <= '0;
      o_stall_cnt <= '0;
      o_wb_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= (pend & ~pend_clr) | pend_set;
      o_inflight  <= inflight_nxt;
      o_stall_cnt <= (o_stall && o_stall_cnt != '1) ? o_stall_cnt + 32'd1 : o_stall_cnt;
      o_wb_err    <= o_wb_err | wb_bad;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed vectors with hand-computed expectations for issue_scoreboard
module tb_issue_scoreboard;
  logic i_clk, i_rst_n, i_issue_vld, i_rs1_used, i_rs2_used, i_rd_wren, i_wb_vld, i_drain;
  logic [4:0] i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_rd;
  logic o_issue_rdy, o_stall, o_drained, o_wb_err;
  logic [3:0] o_inflight;
  logic [31:0] o_stall_cnt;
  int n_cmp = 0, n_bad = 0;

  issue_scoreboard dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_issue_vld(i_issue_vld),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren),
    .i_wb_vld(i_wb_vld), .i_wb_rd(i_wb_rd), .i_drain(i_drain),
    .o_issue_rdy(o_issue_rdy), .o_stall(o_stall), .o_inflight(o_inflight),
    .o_drained(o_drained), .o_stall_cnt(o_stall_cnt), .o_wb_err(o_wb_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    i_issue_vld = 0; i_rs1_used = 0; i_rs2_used = 0; i_rd_wren = 0; i_wb_vld = 0;
    i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_wb_rd = 0;
  endtask

  task automatic iss(input logic [4:0] rd, input logic w, input logic [4:0] a, input logic ua,
                     input logic [4:0] b, input logic ub);
    i_issue_vld = 1; i_rd_addr = rd; i_rd_wren = w;
    i_rs1_addr = a; i_rs1_used = ua; i_rs2_addr = b; i_rs2_used = ub;
  endtask

  task automatic wb(input logic [4:0] rd);
    i_wb_vld = 1; i_wb_rd = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 0; i_drain = 0; clr();
    iss(5'd1, 1, 5'd2, 1, 5'd3, 1);
    #3;
    chk("rst_rdy", o_issue_rdy, 1);
    chk("rst_inflight", o_inflight, 0);
    chk("rst_drained", o_drained, 0);
    chk("rst_stall_cnt", o_stall_cnt, 0);
    chk("rst_wb_err", o_wb_err, 0);
    #9 i_rst_n = 1;
    clr(); tick();
    // RAW stall on x5 until its writeback, which bypasses into the issue cycle
    iss(5'd5, 1, 5'd1, 1, 5'd2, 1); #2 chk("add_rdy", o_issue_rdy, 1); tick();
    iss(5'd6, 1, 5'd5, 1, 5'd1, 1); #2 chk("sub_stall1", o_stall, 1); tick();
    #2 chk("sub_stall2", o_stall, 1); tick();
    wb(5'd5); #2 chk("sub_wb_bypass", o_issue_rdy, 1); tick();
    clr();
    chk("raw_inflight", o_inflight, 1);
    chk("raw_stall_cnt", o_stall_cnt, 2);
    wb(5'd6); tick(); clr();
    chk("raw_retired", o_inflight, 0);
    // same-cycle writeback and re-issue of x7: set wins
    iss(5'd7, 1, 5'd1, 1, 5'd0, 0); tick();
    iss(5'd7, 1, 5'd7, 1, 5'd0, 0); wb(5'd7); #2 chk("addi_rdy", o_issue_rdy, 1); tick();
    clr();
    chk("addi_inflight", o_inflight, 1);
    iss(5'd8, 1, 5'd7, 1, 5'd0, 0); #2 chk("pend7_stall", o_stall, 1); tick();
    clr();
    chk("pend7_stall_cnt", o_stall_cnt, 3);
    wb(5'd7); tick(); clr();
    chk("pend7_retired", o_inflight, 0);
    // capacity: eight non-writing instructions fill the window
    for (int i = 0; i < 8; i++) begin
      iss(5'd0, 0, 5'd0, 0, 5'd0, 0); tick();
    end
    chk("cap_full", o_inflight, 8);
    #2 chk("cap_stall", o_stall, 1); tick();
    wb(5'd0); #2 chk("cap_wb_rdy", o_issue_rdy, 1); tick();
    clr();
    chk("cap_inflight", o_inflight, 8);
    chk("cap_stall_cnt", o_stall_cnt, 4);
    for (int i = 0; i < 8; i++) begin
      wb(5'd0); tick();
    end
    clr();
    chk("cap_retired", o_inflight, 0);
    chk("wb_x0_no_err", o_wb_err, 0);
    // x0 is never a hazard
    iss(5'd0, 1, 5'd0, 1, 5'd0, 1); #2 chk("x0_rdy1", o_issue_rdy, 1); tick();
    #2 chk("x0_rdy2", o_issue_rdy, 1); tick();
    clr();
    chk("x0_inflight", o_inflight, 2);
    wb(5'd0); tick(); tick(); clr();
    chk("x0_err_clean", o_wb_err, 0);
    iss(5'd0, 0, 5'd0, 0, 5'd0, 0); tick(); clr();
    wb(5'd3); tick(); clr();
    chk("wb_x3_err", o_wb_err, 1);
    chk("wb_x3_inflight", o_inflight, 0);
    tick(); tick();
    chk("wb_err_sticky", o_wb_err, 1);
    // drain dropped before empty returns to RUN
    iss(5'd0, 0, 5'd0, 0, 5'd0, 0); tick(); clr();
    i_drain = 1; tick();
    i_drain = 0; i_issue_vld = 1; #2 chk("drain_early_rdy", o_issue_rdy, 0);
    i_issue_vld = 0; tick();
    i_issue_vld = 1; #2 chk("undrain_rdy", o_issue_rdy, 1);
    i_issue_vld = 0; wb(5'd0); tick(); clr();
    chk("undrain_inflight", o_inflight, 0);
    // full drain with three in flight
    for (int i = 0; i < 3; i++) begin
      iss(5'd0, 0, 5'd0, 0, 5'd0, 0); tick();
    end
    clr();
    chk("drain_inflight", o_inflight, 3);
    i_drain = 1; tick();
    i_issue_vld = 1; #2 chk("drain_rdy", o_issue_rdy, 0);
    chk("drain_stall", o_stall, 1);
    i_issue_vld = 0;
    wb(5'd0); tick(); tick();
    #2 chk("drained_pre", o_drained, 0); tick();
    clr();
    chk("drained", o_drained, 1);
    chk("drained_inflight", o_inflight, 0);
    i_drain = 0; #2 chk("drained_hold", o_drained, 1); tick();
    chk("run_again", o_drained, 0);
    i_issue_vld = 1; #2 chk("run_rdy", o_issue_rdy, 1);
    i_issue_vld = 0;
    // asynchronous reset with five in flight
    for (int i = 0; i < 5; i++) begin
      iss(5'(10 + i), 1, 5'd0, 0, 5'd0, 0); tick();
    end
    clr();
    chk("pre_rst_inflight", o_inflight, 5);
    chk("pre_rst_stall_cnt", o_stall_cnt, 4);
    #3 i_rst_n = 0;
    #1;
    chk("async_inflight", o_inflight, 0);
    chk("async_stall_cnt", o_stall_cnt, 0);
    chk("async_wb_err", o_wb_err, 0);
    chk("async_drained", o_drained, 0);
    #3 i_rst_n = 1;
    tick();
    iss(5'd11, 1, 5'd10, 1, 5'd0, 0); #2 chk("post_rst_rdy", o_issue_rdy, 1);
    i_issue_vld = 0; wb(5'd10); tick(); clr();
    chk("post_rst_wb_err", o_wb_err, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
